// File: rtl/csa_accumulator.sv
`timescale 1ns/1ps
// Carry-save accumulator feeding final_addition: folds (A,B) pairs into a redundant sum/carry pair.
// Optional synchronous packet abort port `clr` is enabled by defining CSA_ACC_CLEAR_EN.
module csa_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CSA_ACC_CLEAR_EN
    input  logic             clr,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [WIDTH-1:0] out_carry,
    output logic [CNT_W-1:0] out_beats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0] acc_carry;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             clr_i;
    logic [WIDTH-1:0] base_sum;
    logic [WIDTH-1:0] base_carry;
    logic [WIDTH-1:0] nxt_sum;
    logic [WIDTH-1:0] nxt_carry;
    logic [CNT_W-1:0] cnt_nxt;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic [WIDTH-1:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // Two chained 3:2 rows; carries shifted out of the top bit are dropped.
    function automatic logic [2*WIDTH-1:0] compress(input logic [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0] c,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s1, c1, s2, c2;
        s1 = s ^ c ^ a;
        c1 = maj3(s, c, a) << 1;
        s2 = s1 ^ c1 ^ b;
        c2 = maj3(s1, c1, b) << 1;
        return {c2, s2};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
    endfunction

`ifdef CSA_ACC_CLEAR_EN
    assign clr_i = clr;
`else
    assign clr_i = 1'b0;
`endif

    assign in_ready = (state != DONE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        base_sum   = (state == IDLE) ? '0 : acc_sum;
        base_carry = (state == IDLE) ? '0 : acc_carry;
        {nxt_carry, nxt_sum} = compress(base_sum, base_carry, in_a, in_b);
        cnt_nxt = (state == IDLE) ? CNT_ONE : sat_inc(cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_sum   <= '0;
            acc_carry <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_beats <= '0;
        end else if (clr_i) begin
            state     <= IDLE;
            acc_sum   <= '0;
            acc_carry <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_beats <= '0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (in_last) begin
                            out_sum   <= nxt_sum;
                            out_carry <= nxt_carry;
                            out_beats <= cnt_nxt;
                            out_valid <= 1'b1;
                            acc_sum   <= '0;
                            acc_carry <= '0;
                            cnt       <= '0;
                            state     <= DONE;
                        end else begin
                            acc_sum   <= nxt_sum;
                            acc_carry <= nxt_carry;
                            cnt       <= cnt_nxt;
                            state     <= ACC;
                        end
                    end
                end
                DONE: begin
                    // Output pair is held until downstream takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accumulator.sv
`timescale 1ns/1ps
// Randomized bench for csa_accumulator against a plain-arithmetic packet-sum model.
module tb_csa_accumulator;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [WIDTH-1:0] out_carry;
    logic [CNT_W-1:0] out_beats;
`ifdef CSA_ACC_CLEAR_EN
    logic             clr;
`endif

    always #5 clk = ~clk;

    csa_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CSA_ACC_CLEAR_EN
        .clr       (clr),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_beats (out_beats)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] ref_sum = 16'h0;
    int          ref_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] red_sum();
        return out_sum + out_carry;
    endfunction

    function automatic logic [31:0] exp_beats();
        return (ref_cnt > 255) ? 32'd255 : 32'(ref_cnt);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic last);
        check_eq("in_ready_before_beat", in_ready, 1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        ref_sum  = ref_sum + a + b;
        ref_cnt++;
    endtask

    // Checks the presented result, optionally holds it under backpressure, then takes it.
    task automatic take_result(input string tag, input int hold, input logic junk);
        logic [15:0] s0, c0;
        logic [7:0]  b0;
        check_eq({tag, "_valid"}, out_valid, 1);
        check_eq({tag, "_in_ready"}, in_ready, 0);
        check_eq({tag, "_sum"}, red_sum(), ref_sum);
        check_eq({tag, "_beats"}, out_beats, exp_beats());
        s0 = out_sum; c0 = out_carry; b0 = out_beats;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_last = 1'b1;
            end
            cycle();
            check_eq({tag, "_hold_valid"}, out_valid, 1);
            check_eq({tag, "_hold_in_ready"}, in_ready, 0);
            check_eq({tag, "_hold_sum"}, out_sum, s0);
            check_eq({tag, "_hold_carry"}, out_carry, c0);
            check_eq({tag, "_hold_beats"}, out_beats, b0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check_eq({tag, "_drop_valid"}, out_valid, 0);
        check_eq({tag, "_idle_in_ready"}, in_ready, 1);
        ref_sum = 16'h0;
        ref_cnt = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        int          len;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
`ifdef CSA_ACC_CLEAR_EN
        clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_sum", out_sum, 0);
        check_eq("rst_carry", out_carry, 0);
        check_eq("rst_beats", out_beats, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_eq("rst_in_ready", in_ready, 1);

        // Two-beat packet
        beat(16'd3, 16'd4, 1'b0);
        check_eq("two_beat_no_early_valid", out_valid, 0);
        beat(16'd10, 16'd20, 1'b1);
        check_eq("two_beat_sum37", red_sum(), 16'd37);
        take_result("two_beat", 0, 1'b0);

        // Wrap cases, also checking the single-beat redundant form directly
        beat(16'hFFFF, 16'h0001, 1'b1);
        check_eq("wrap1_sum_vec", out_sum, 16'hFFFE);
        check_eq("wrap1_carry_vec", out_carry, 16'h0002);
        take_result("wrap1", 0, 1'b0);
        beat(16'hFFFF, 16'hFFFF, 1'b1);
        check_eq("wrap2_sum_vec", out_sum, 16'h0000);
        check_eq("wrap2_carry_vec", out_carry, 16'hFFFE);
        take_result("wrap2", 0, 1'b0);

        // Backpressure with a beat offered while the result is held
        beat(16'd100, 16'd200, 1'b0);
        beat(16'd7, 16'd9, 1'b1);
        take_result("bp", 5, 1'b1);

        // Long packet to saturate the counter
        for (int i = 0; i < 300; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            beat(a, b, (i == 299));
        end
        take_result("sat300", 1, 1'b0);

        // Random short packets with input gaps and output backpressure
        for (int p = 0; p < 25; p++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                beat(a, b, (i == len - 1));
                if (i != len - 1 && $urandom_range(0, 3) == 0)
                    repeat ($urandom_range(1, 3)) cycle();
            end
            take_result("rand", int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset mid-packet
        beat(16'd1, 16'd1, 1'b0);
        beat(16'd1, 16'd1, 1'b0);
        beat(16'd1, 16'd1, 1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_sum", out_sum, 0);
        check_eq("midrst_carry", out_carry, 0);
        check_eq("midrst_beats", out_beats, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        check_eq("midrst_in_ready", in_ready, 1);
        ref_sum = 16'h0;
        ref_cnt = 0;
        beat(16'd5, 16'd6, 1'b1);
        check_eq("after_rst_sum11", red_sum(), 16'd11);
        take_result("after_rst", 0, 1'b0);

`ifdef CSA_ACC_CLEAR_EN
        beat(16'd7, 16'd7, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_a = 16'd9; in_b = 16'd9; in_last = 1'b0;
        cycle();
        clr = 1'b0; in_valid = 1'b0;
        check_eq("clr_valid", out_valid, 0);
        check_eq("clr_in_ready", in_ready, 1);
        ref_sum = 16'h0;
        ref_cnt = 0;
        beat(16'd2, 16'd3, 1'b1);
        check_eq("after_clr_sum5", red_sum(), 16'd5);
        take_result("after_clr", 0, 1'b0);
        beat(16'd4, 16'd4, 1'b1);
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_eq("clr_done_valid", out_valid, 0);
        check_eq("clr_done_sum", out_sum, 0);
        check_eq("clr_done_beats", out_beats, 0);
        check_eq("clr_done_in_ready", in_ready, 1);
        ref_sum = 16'h0;
        ref_cnt = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
